clk_en_gen: RTL and testbench

Multi-channel fractional clock-enable generator on the 74.25 MHz system clock. It produces `NUM_CH` independent single-cycle enable strobes, each at a runtime-programmable rate `f_clk * inc / 2^ACC_W` with a programmable phase offset. This lets downstream logic such as the CPU step, the video pixel enable and audio sample ticks run from one clock instead of extra hard PLL outputs. It reports a `locked` status equivalent to a PLL lock, after atomic reconfiguration and a settle period.

---
 rtl/clk_en_gen_pkg.sv | 20 ++
 rtl/clk_en_acc.sv | 51 +++++
 rtl/clk_en_gen.sv | 130 +++++++++++++
 tb/tb_clk_en_gen.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_en_gen_pkg.sv
// Shared types and helpers for the clk_en_gen fractional clock-enable generator.
package clk_en_gen_pkg;

   typedef enum logic [1:0] {
      ST_RESET,
      ST_APPLY,
      ST_SETTLE,
      ST_LOCKED
   } state_t;

   localparam int NUM_CH_MAX = 16;
   localparam int ACC_W_MIN  = 8;
   localparam int ACC_W_MAX  = 48;

   // Index width for n items, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clk_en_acc.sv
// One phase-accumulator channel: active inc/acc, registered carry strobe.
// Optional CLK_EN_GEN_DUTY_EN adds the registered accumulator MSB as a duty-cycle level.
module clk_en_acc
   import clk_en_gen_pkg::*;
#(
   parameter int               ACC_W       = 32,
   parameter logic [ACC_W-1:0] DEFAULT_INC = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [ACC_W-1:0] load_inc,
   input  logic [ACC_W-1:0] load_phase,
`ifdef CLK_EN_GEN_DUTY_EN
   output logic             msb,
`endif
   output logic             ce
);

   logic [ACC_W-1:0] inc;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] load_acc;
   logic [ACC_W:0]   sum;

   assign sum      = {1'b0, acc} + {1'b0, inc};
   // The APPLY cycle already takes the first step at the new rate; its carry is dropped.
   assign load_acc = load_phase + load_inc;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         inc <= DEFAULT_INC;
         acc <= '0;
         ce  <= 1'b0;
      end else if (load) begin
         inc <= load_inc;
         acc <= load_acc;
         ce  <= 1'b0;
      end else begin
         acc <= sum[ACC_W-1:0];
         ce  <= sum[ACC_W];
      end
   end

`ifdef CLK_EN_GEN_DUTY_EN
   always_ff @(posedge clk) begin
      if (!reset_n) msb <= 1'b0;
      else          msb <= acc[ACC_W-1];
   end
`endif

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel fractional clock-enable generator with shadow config, atomic commit and lock status.
// Optional CLK_EN_GEN_DUTY_EN adds the clk_out duty-cycle outputs.
module clk_en_gen
   import clk_en_gen_pkg::*;
#(
   parameter int               NUM_CH      = 4,
   parameter int               ACC_W       = 32,
   parameter int               LOCK_CYCLES = 1024,
   parameter logic [ACC_W-1:0] DEFAULT_INC = '0,
   parameter int               CH_W        = idx_w(NUM_CH)
) (
   input  logic              clk_74a,
   input  logic              reset_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [ACC_W-1:0]  cfg_inc,
   input  logic [ACC_W-1:0]  cfg_phase,
   input  logic              cfg_commit,
   output logic              cfg_err,
   output logic [NUM_CH-1:0] ce,
`ifdef CLK_EN_GEN_DUTY_EN
   output logic [NUM_CH-1:0] clk_out,
`endif
   output logic              locked
);

   localparam int              CNT_W    = idx_w(LOCK_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

   typedef struct packed {
      logic [ACC_W-1:0] inc;
      logic [ACC_W-1:0] phase;
   } ch_cfg_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   ch_cfg_t           shadow [NUM_CH];
   logic [NUM_CH-1:0] ch_hit;
   logic              in_range;
   logic              wr_acc;
   logic              commit_acc;
   logic              apply;

   assign cfg_ready  = (state == ST_SETTLE) || (state == ST_LOCKED);
   assign locked     = (state == ST_LOCKED);
   assign apply      = (state == ST_APPLY);
   assign wr_acc     = cfg_valid && cfg_ready;
   assign commit_acc = cfg_commit && cfg_ready;
   assign in_range   = |ch_hit;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) ch_hit[i] = (cfg_ch == CH_W'(i));
   end

   always_comb begin
      // NOTE: defaults first so every path assigns the next values and no latch is inferred.
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_RESET: begin
            state_nxt = ST_SETTLE;
            cnt_nxt   = '0;
         end
         ST_APPLY: begin
            cnt_nxt   = cnt + 1'b1;
            state_nxt = (cnt == CNT_LAST) ? ST_LOCKED : ST_SETTLE;
         end
         ST_SETTLE: begin
            if (commit_acc) begin
               state_nxt = ST_APPLY;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = ST_LOCKED;
            end else begin
               cnt_nxt   = cnt + 1'b1;
            end
         end
         ST_LOCKED: begin
            if (commit_acc) begin
               state_nxt = ST_APPLY;
               cnt_nxt   = '0;
            end
         end
         default: state_nxt = ST_RESET;
      endcase
   end

   always_ff @(posedge clk_74a) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (!reset_n) begin
         state   <= ST_RESET;
         cnt     <= '0;
         cfg_err <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         cfg_err <= wr_acc && !in_range;
      end
   end

   always_ff @(posedge clk_74a) begin
      // NOTE: the shadow array is a handful of flops that must discard pending writes on reset, so it is reset, unlike a RAM.
      if (!reset_n) begin
         for (int i = 0; i < NUM_CH; i++) shadow[i] <= '{inc: DEFAULT_INC, phase: '0};
      end else if (wr_acc) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (ch_hit[i]) shadow[i] <= '{inc: cfg_inc, phase: cfg_phase};
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clk_en_acc #(
         .ACC_W       (ACC_W),
         .DEFAULT_INC (DEFAULT_INC)
      ) u_acc (
         .clk        (clk_74a),
         .reset_n    (reset_n),
         .load       (apply),
         .load_inc   (shadow[g].inc),
         .load_phase (shadow[g].phase),
`ifdef CLK_EN_GEN_DUTY_EN
         .msb        (clk_out[g]),
`endif
         .ce         (ce[g])
      );
   end

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed self-checking bench for clk_en_gen with ACC_W=8, NUM_CH=2, LOCK_CYCLES=4.
// Connects clk_out as well when CLK_EN_GEN_DUTY_EN is defined.
module tb_clk_en_gen;

   localparam int NUM_CH      = 2;
   localparam int ACC_W       = 8;
   localparam int LOCK_CYCLES = 4;
   localparam int CH_W        = 2;

   logic              clk_74a = 1'b0;
   logic              reset_n;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [CH_W-1:0]   cfg_ch;
   logic [ACC_W-1:0]  cfg_inc;
   logic [ACC_W-1:0]  cfg_phase;
   logic              cfg_commit;
   logic              cfg_err;
   logic [NUM_CH-1:0] ce;
   logic              locked;
`ifdef CLK_EN_GEN_DUTY_EN
   logic [NUM_CH-1:0] clk_out;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk_74a = ~clk_74a;

   clk_en_gen #(
      .NUM_CH      (NUM_CH),
      .ACC_W       (ACC_W),
      .LOCK_CYCLES (LOCK_CYCLES),
      .DEFAULT_INC (8'd0),
      .CH_W        (CH_W)
   ) dut (
      .clk_74a    (clk_74a),
      .reset_n    (reset_n),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_ch     (cfg_ch),
      .cfg_inc    (cfg_inc),
      .cfg_phase  (cfg_phase),
      .cfg_commit (cfg_commit),
      .cfg_err    (cfg_err),
      .ce         (ce),
`ifdef CLK_EN_GEN_DUTY_EN
      .clk_out    (clk_out),
`endif
      .locked     (locked)
   );

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk_74a);
      #1;
   endtask

   // One-cycle write (optionally with commit); returns in the cycle after acceptance.
   task automatic cycle_write(input logic [CH_W-1:0] ch, input logic [ACC_W-1:0] inc,
                              input logic [ACC_W-1:0] phase, input logic commit);
      cfg_valid  = 1'b1;
      cfg_ch     = ch;
      cfg_inc    = inc;
      cfg_phase  = phase;
      cfg_commit = commit;
      tick();
      cfg_valid  = 1'b0;
      cfg_commit = 1'b0;
   endtask

   // Commit pulse accepted at cycle T; returns in cycle T+1.
   task automatic do_commit();
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      tick();
      n_checks++; if (ce !== 2'b00)     $display("FAIL reset_ce got %b want 00", ce);        else n_pass++;
      n_checks++; if (locked !== 1'b0)  $display("FAIL reset_locked got %b want 0", locked); else n_pass++;
      n_checks++; if (cfg_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", cfg_ready); else n_pass++;
      n_checks++; if (cfg_err !== 1'b0) $display("FAIL reset_err got %b want 0", cfg_err);   else n_pass++;
      reset_n = 1'b1;
      tick();
      n_checks++; if (cfg_ready !== 1'b1) $display("FAIL release_ready got %b want 1", cfg_ready); else n_pass++;
      for (int k = 0; k <= 4; k++) begin
         n_checks++;
         if (locked !== logic'(k >= 4)) $display("FAIL release_locked k=%0d got %b want %b", k, locked, logic'(k >= 4));
         else n_pass++;
         if (k < 4) tick();
      end
   endtask

   task automatic test_basic();
      logic e0;
      cycle_write(2'd0, 8'd64, 8'd0, 1'b0);
      n_checks++; if (cfg_err !== 1'b0) $display("FAIL basic_no_err got %b want 0", cfg_err); else n_pass++;
      do_commit();
      for (int k = 1; k <= 13; k++) begin
         e0 = (k >= 5) && ((k - 5) % 4 == 0);
         n_checks++; if (ce[0] !== e0)   $display("FAIL basic_ce0 k=%0d got %b want %b", k, ce[0], e0); else n_pass++;
         n_checks++; if (ce[1] !== 1'b0) $display("FAIL basic_ce1 k=%0d got %b want 0", k, ce[1]);     else n_pass++;
         n_checks++;
         if (locked !== logic'(k >= 5)) $display("FAIL basic_locked k=%0d got %b want %b", k, locked, logic'(k >= 5));
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_phase();
      logic e0, e1;
      cycle_write(2'd1, 8'd64, 8'd128, 1'b0);
      do_commit();
      for (int k = 1; k <= 13; k++) begin
         e0 = (k >= 5) && ((k - 5) % 4 == 0);
         e1 = (k >= 3) && ((k - 3) % 4 == 0);
         if (k >= 2) begin
            n_checks++; if (ce[0] !== e0) $display("FAIL phase_ce0 k=%0d got %b want %b", k, ce[0], e0); else n_pass++;
            n_checks++; if (ce[1] !== e1) $display("FAIL phase_ce1 k=%0d got %b want %b", k, ce[1], e1); else n_pass++;
         end
         tick();
      end
   endtask

   task automatic test_write_commit();
      logic e0, e1;
      cycle_write(2'd1, 8'd32, 8'd0, 1'b1);
      for (int k = 1; k <= 18; k++) begin
         e0 = (k >= 5) && ((k - 5) % 4 == 0);
         e1 = (k >= 9) && ((k - 9) % 8 == 0);
         if (k >= 2) begin
            n_checks++; if (ce[0] !== e0) $display("FAIL wc_ce0 k=%0d got %b want %b", k, ce[0], e0); else n_pass++;
            n_checks++; if (ce[1] !== e1) $display("FAIL wc_ce1 k=%0d got %b want %b", k, ce[1], e1); else n_pass++;
         end
         tick();
      end
   endtask

   task automatic test_cfg_err();
      logic e0, e1;
      n_checks++; if (cfg_ready !== 1'b1) $display("FAIL err_ready_pre got %b want 1", cfg_ready); else n_pass++;
      cycle_write(2'd3, 8'd255, 8'd255, 1'b0);
      n_checks++; if (cfg_err !== 1'b1)   $display("FAIL err_pulse got %b want 1", cfg_err);       else n_pass++;
      n_checks++; if (cfg_ready !== 1'b1) $display("FAIL err_ready got %b want 1", cfg_ready);     else n_pass++;
      tick();
      n_checks++; if (cfg_err !== 1'b0)   $display("FAIL err_clear got %b want 0", cfg_err);       else n_pass++;
      do_commit();
      for (int k = 1; k <= 18; k++) begin
         e0 = (k >= 5) && ((k - 5) % 4 == 0);
         e1 = (k >= 9) && ((k - 9) % 8 == 0);
         if (k >= 2) begin
            n_checks++; if (ce[0] !== e0) $display("FAIL err_ce0 k=%0d got %b want %b", k, ce[0], e0); else n_pass++;
            n_checks++; if (ce[1] !== e1) $display("FAIL err_ce1 k=%0d got %b want %b", k, ce[1], e1); else n_pass++;
         end
         tick();
      end
   endtask

   task automatic test_commit_in_apply();
      do_commit();
      n_checks++; if (cfg_ready !== 1'b0) $display("FAIL apply_ready got %b want 0", cfg_ready); else n_pass++;
      n_checks++; if (locked !== 1'b0)    $display("FAIL apply_locked got %b want 0", locked);   else n_pass++;
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      for (int k = 2; k <= 6; k++) begin
         n_checks++;
         if (locked !== logic'(k >= 5)) $display("FAIL apply_ignore_locked k=%0d got %b want %b", k, locked, logic'(k >= 5));
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_back_to_back();
      do_commit();
      tick();
      n_checks++; if (locked !== 1'b0) $display("FAIL b2b_settle_locked got %b want 0", locked); else n_pass++;
      do_commit();
      for (int k = 1; k <= 6; k++) begin
         n_checks++;
         if (locked !== logic'(k >= 5)) $display("FAIL b2b_locked k=%0d got %b want %b", k, locked, logic'(k >= 5));
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_reset_mid_settle();
      do_commit();
      tick();
      cycle_write(2'd0, 8'd16, 8'd0, 1'b0);
      n_checks++; if (locked !== 1'b0) $display("FAIL rst_pre_locked got %b want 0", locked); else n_pass++;
      reset_n = 1'b0;
      tick();
      n_checks++; if (ce !== 2'b00)       $display("FAIL rst_ce got %b want 00", ce);              else n_pass++;
      n_checks++; if (locked !== 1'b0)    $display("FAIL rst_locked got %b want 0", locked);       else n_pass++;
      n_checks++; if (cfg_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", cfg_ready);     else n_pass++;
      reset_n = 1'b1;
      tick();
      for (int k = 0; k <= 4; k++) begin
         n_checks++; if (ce !== 2'b00) $display("FAIL rst_release_ce k=%0d got %b want 00", k, ce); else n_pass++;
         n_checks++;
         if (locked !== logic'(k >= 4)) $display("FAIL rst_release_locked k=%0d got %b want %b", k, locked, logic'(k >= 4));
         else n_pass++;
         tick();
      end
      do_commit();
      for (int k = 1; k <= 20; k++) begin
         n_checks++; if (ce !== 2'b00) $display("FAIL rst_discard_ce k=%0d got %b want 00", k, ce); else n_pass++;
         tick();
      end
   endtask

   initial begin
      reset_n    = 1'b0;
      cfg_valid  = 1'b0;
      cfg_ch     = '0;
      cfg_inc    = '0;
      cfg_phase  = '0;
      cfg_commit = 1'b0;
      test_reset();
      test_basic();
      test_phase();
      test_write_commit();
      test_cfg_err();
      test_commit_in_apply();
      test_back_to_back();
      test_reset_mid_settle();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
